// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types, init ROM and helpers for the HD44780 write controller.
package lcd_pkg;
    typedef enum logic [2:0] {
        S_POWERUP,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } lcd_state_e;

    localparam int LCD_INIT_LEN = 6;
    localparam int LCD_RS_BIT   = 8;
    localparam int LCD_DATA_MSB = 7;

    localparam logic [7:0] LCD_INIT_SEQ [LCD_INIT_LEN] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    // Clear display and return home need the long execution wait
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return !rs && (b == 8'h01 || b == 8'h02 || b == 8'h03);
    endfunction
endpackage

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 8-bit write-only bus driver with power-up init and a
// one-deep valid/ready request port; one down-counter times every phase.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_POWERUP = 2000000,
    parameter int T_SETUP   = 2,
    parameter int T_EN      = 12,
    parameter int T_HOLD    = 2,
    parameter int T_CMD     = 2500,
    parameter int T_CLEAR   = 82000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr_vld,
    input  logic [31:0] i_wr_data,
    output logic        o_wr_rdy,
    output logic        o_init_done,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data
);
    localparam int M1    = T_POWERUP > T_CLEAR ? T_POWERUP : T_CLEAR;
    localparam int M2    = T_CMD > T_EN ? T_CMD : T_EN;
    localparam int M3    = T_SETUP > T_HOLD ? T_SETUP : T_HOLD;
    localparam int M12   = M1 > M2 ? M1 : M2;
    localparam int T_MAX = M12 > M3 ? M12 : M3;
    localparam int CW    = $clog2(T_MAX + 1);
    localparam int IW    = $clog2(LCD_INIT_LEN);

    lcd_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d;
    logic          done_q, done_d;
    logic          en_q, rdy_q, on_q;
    logic          unused_bits;

    assign unused_bits = ^i_wr_data[31:LCD_RS_BIT+1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - CW'(1);
        idx_d   = idx_q;
        data_d  = data_q;
        rs_d    = rs_q;
        done_d  = done_q;
        case (state_q)
            S_POWERUP: if (cnt_q == '0) begin
                state_d = S_SETUP;
                cnt_d   = CW'(T_SETUP - 1);
                idx_d   = '0;
                data_d  = LCD_INIT_SEQ[0];
                rs_d    = 1'b0;
            end
            S_SETUP: if (cnt_q == '0) begin
                state_d = S_PULSE;
                cnt_d   = CW'(T_EN - 1);
            end
            S_PULSE: if (cnt_q == '0) begin
                state_d = S_HOLD;
                cnt_d   = CW'(T_HOLD - 1);
            end
            S_HOLD: if (cnt_q == '0) begin
                state_d = S_WAIT;
                cnt_d   = is_long_cmd(rs_q, data_q) ? CW'(T_CLEAR - 1) : CW'(T_CMD - 1);
            end
            S_WAIT: if (cnt_q == '0) begin
                if (!done_q && idx_q < IW'(LCD_INIT_LEN - 1)) begin
                    state_d = S_SETUP;
                    cnt_d   = CW'(T_SETUP - 1);
                    idx_d   = idx_q + IW'(1);
                    data_d  = LCD_INIT_SEQ[idx_q + IW'(1)];
                    rs_d    = 1'b0;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_IDLE: begin
                cnt_d = cnt_q;
                if (i_wr_vld && rdy_q) begin
                    state_d = S_SETUP;
                    cnt_d   = CW'(T_SETUP - 1);
                    data_d  = i_wr_data[LCD_DATA_MSB:0];
                    rs_d    = i_wr_data[LCD_RS_BIT];
                end
            end
            default: state_d = S_POWERUP;
        endcase
    end

    // Strobes are derived from the next state so they line up with it exactly
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_POWERUP;
            cnt_q   <= CW'(T_POWERUP - 1);
            idx_q   <= '0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            rdy_q   <= 1'b0;
            on_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            done_q  <= done_d;
            en_q    <= state_d == S_PULSE;
            rdy_q   <= state_d == S_IDLE;
            on_q    <= 1'b1;
        end
    end

    assign o_wr_rdy    = rdy_q;
    assign o_init_done = done_q;
    assign o_lcd_on    = on_q;
    assign o_lcd_en    = en_q;
    assign o_lcd_rs    = rs_q;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_data  = data_q;
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: scoreboard bench; expected EN pulses are queued when stimulus
// is issued and popped by a bus monitor on each EN rise.
module tb_lcd_ctrl;
    logic        clk, rst, vld;
    logic [31:0] wdata;
    logic        rdy, done, on, en, rs, rw;
    logic [7:0]  ldata;

    typedef struct packed {
        logic        rs;
        logic [7:0]  d;
        logic [15:0] gap;
    } exp_t;

    exp_t q[$];
    int   total = 0, bad = 0;
    int   cyc = 0, acc_cyc = 0, rdy_cyc = 0;

    lcd_ctrl #(
        .T_POWERUP(10), .T_SETUP(1), .T_EN(3), .T_HOLD(1), .T_CMD(4), .T_CLEAR(8)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_vld(vld), .i_wr_data(wdata),
        .o_wr_rdy(rdy), .o_init_done(done), .o_lcd_on(on), .o_lcd_en(en),
        .o_lcd_rs(rs), .o_lcd_rw(rw), .o_lcd_data(ldata)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    bit         in_pulse = 0;
    int         width = 0, prev_rise = -1;
    logic [7:0] rise_data;
    exp_t       e;

    always @(negedge clk) begin
        if (rst) begin
            in_pulse  = 0;
            width     = 0;
            prev_rise = -1;
        end else if (en && !in_pulse) begin
            in_pulse  = 1;
            width     = 1;
            rise_data = ldata;
            chk("rw", {31'd0, rw}, 0);
            if (q.size() == 0) chk("extra_pulse", 1, 0);
            else begin
                e = q.pop_front();
                chk("pulse_data", {24'd0, ldata}, {24'd0, e.d});
                chk("pulse_rs", {31'd0, rs}, {31'd0, e.rs});
                if (e.gap != 0) chk("pulse_gap", cyc - prev_rise, {16'd0, e.gap});
            end
            prev_rise = cyc;
        end else if (en) width++;
        else if (in_pulse) begin
            in_pulse = 0;
            chk("pulse_width", width, 3);
            chk("pulse_stable", {24'd0, ldata}, {24'd0, rise_data});
        end
    end

    task automatic push_init();
        logic [7:0] seq [6];
        logic [15:0] gaps [6];
        seq  = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        gaps = '{16'd0, 16'd9, 16'd9, 16'd9, 16'd9, 16'd13};
        for (int i = 0; i < 6; i++) q.push_back('{rs: 1'b0, d: seq[i], gap: gaps[i]});
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 300) begin @(negedge clk); n++; end
        chk("init_done_cyc", cyc, 68);
        chk("init_rdy", {31'd0, rdy}, 1);
        chk("init_q_empty", q.size(), 0);
    endtask

    task automatic send(input logic [31:0] w, input int lat, input bit keep, input bit poke);
        int k, n;
        vld   = 1;
        wdata = w;
        n     = 0;
        while (!rdy && n < 500) begin @(negedge clk); n++; end
        chk("accept", {31'd0, rdy}, 1);
        k       = cyc;
        acc_cyc = k;
        q.push_back('{rs: w[8], d: w[7:0], gap: 16'd0});
        @(negedge clk);
        chk("rdy_drop", {31'd0, rdy}, 0);
        if (!keep) vld = 0;
        @(negedge clk);
        chk("en_lat", {31'd0, en}, 1);
        chk("req_data", {24'd0, ldata}, {24'd0, w[7:0]});
        chk("req_rs", {31'd0, rs}, {31'd0, w[8]});
        if (poke) begin
            vld   = 1;
            wdata = 32'h155;
            @(negedge clk);
            vld = 0;
            chk("poke_data", {24'd0, ldata}, {24'd0, w[7:0]});
        end
        n = 0;
        while (!rdy && n < 500) begin @(negedge clk); n++; end
        chk("rdy_lat", cyc - k, lat);
        rdy_cyc = cyc;
    endtask

    initial begin
        int r;
        rst   = 1;
        vld   = 0;
        wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst = 0;
        chk("rst_state", {rdy, done, on, en, rs, rw, ldata}, 0);
        push_init();
        @(negedge clk);
        chk("on_after_rst", {31'd0, on}, 1);
        chk("rdy_powerup", {31'd0, rdy}, 0);
        wait_done();

        send(32'h141, 10, 0, 0);
        send(32'h001, 14, 0, 0);
        send(32'h101, 10, 0, 0);
        send(32'h142, 10, 1, 0);
        r = rdy_cyc;
        send(32'h143, 10, 0, 0);
        chk("b2b_accept", acc_cyc, r);
        send(32'h144, 10, 0, 1);
        repeat (3) @(negedge clk);
        chk("no_extra_q", q.size(), 0);

        vld   = 1;
        wdata = 32'h146;
        q.push_back('{rs: 1'b1, d: 8'h46, gap: 16'd0});
        @(negedge clk);
        vld = 0;
        @(negedge clk);
        chk("en_before_rst", {31'd0, en}, 1);
        #1 rst = 1;
        @(negedge clk);
        chk("rst_mid_en", {31'd0, en}, 0);
        chk("rst_mid_done", {31'd0, done}, 0);
        chk("rst_mid_rdy", {31'd0, rdy}, 0);
        #1 rst = 0;
        q.delete();
        push_init();
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
